// File: rtl/stream_mux_pkg.sv
// Shared definitions for the stream multiplexer: arbitration mode encodings,
// output-stage states and the channel-index width helpers.
package stream_mux_pkg;

  typedef enum logic {
    MODE_SEL = 1'b0,
    MODE_RR  = 1'b1
  } mode_e;

  typedef enum logic {
    StEmpty = 1'b0,
    StFull  = 1'b1
  } out_state_e;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r++;
    end
    return r;
  endfunction

  // A single channel still needs a one-bit index.
  function automatic int unsigned sel_width(input int unsigned n);
    return (clog2(n) > 0) ? clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first requesting channel searching upward from ptr+1,
// wrapping modulo N (also for non-power-of-two N).
module rr_pick import stream_mux_pkg::*; #(
  parameter int unsigned N = 4,
  localparam int unsigned SELW = sel_width(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic            any,
  output logic [SELW-1:0] idx
);

  int unsigned start;
  int unsigned c;

  always_comb begin
    any   = 1'b0;
    idx   = '0;
    c     = 0;
    start = (32'(ptr) >= N - 1) ? 0 : 32'(ptr) + 1;
    for (int unsigned k = 0; k < N; k++) begin
      c = start + k;
      if (c >= N) begin
        c = c - N;
      end
      if (!any && req[c[SELW-1:0]]) begin
        any = 1'b1;
        idx = c[SELW-1:0];
      end
    end
  end

endmodule

// File: rtl/stream_mux.sv
// N-to-1 valid/ready stream multiplexer with fixed-select or round-robin
// arbitration feeding a single registered output stage.
module stream_mux import stream_mux_pkg::*; #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N     = 4,
  localparam int unsigned SELW = sel_width(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SELW-1:0]      out_grant
);

  out_state_e        state_q;
  logic [WIDTH-1:0]  data_q;
  logic [SELW-1:0]   grant_q;
  logic [SELW-1:0]   rr_ptr_q, rr_ptr_d;

  mode_e             mode_w;
  logic              rr_any;
  logic [SELW-1:0]   rr_idx;
  logic              fix_any;
  logic              has_win;
  logic [SELW-1:0]   win;
  logic [WIDTH-1:0]  win_data;
  logic              load;
  logic              xfer_in;

  assign mode_w = mode_e'(mode);

  rr_pick #(
    .N(N)
  ) u_rr_pick (
    .req(in_valid),
    .ptr(rr_ptr_q),
    .any(rr_any),
    .idx(rr_idx)
  );

  // Fixed select; an out-of-range sel never matches any channel.
  always_comb begin
    fix_any = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (32'(sel) == i && in_valid[i]) begin
        fix_any = 1'b1;
      end
    end
  end

  always_comb begin
    if (mode_w == MODE_RR) begin
      has_win = rr_any;
      win     = rr_idx;
    end else begin
      has_win = fix_any;
      win     = sel;
    end
  end

  assign load    = (state_q == StEmpty) || out_ready;
  assign xfer_in = load && has_win && !rst;

  always_comb begin
    in_ready = '0;
    win_data = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (32'(win) == i) begin
        in_ready[i] = xfer_in;
        win_data    = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (xfer_in && mode_w == MODE_RR) begin
      rr_ptr_d = win;
    end
  end

  // Output stage: load when empty or when the held word leaves this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StEmpty;
      data_q   <= '0;
      grant_q  <= '0;
      rr_ptr_q <= SELW'(N - 1);
    end else begin
      rr_ptr_q <= rr_ptr_d;
      if (load) begin
        if (has_win) begin
          state_q <= StFull;
          data_q  <= win_data;
          grant_q <= win;
        end else begin
          state_q <= StEmpty;
        end
      end
    end
  end

  assign out_valid = (state_q == StFull);
  assign out_data  = data_q;
  assign out_grant = grant_q;

endmodule

// File: tb/tb_stream_mux.sv
// Self-checking bench for stream_mux: behavioural model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_stream_mux;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic        mode;
  logic [1:0]  sel;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_grant;

  logic        rst6;
  logic [47:0] in_data6;
  logic [5:0]  in_valid6;
  logic [5:0]  in_ready6;
  logic        mode6;
  logic [2:0]  sel6;
  logic [7:0]  out_data6;
  logic        out_valid6;
  logic        out_ready6;
  logic [2:0]  out_grant6;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  stream_mux #(
    .WIDTH(8),
    .N(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .mode(mode),
    .sel(sel),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_grant(out_grant)
  );

  stream_mux #(
    .WIDTH(8),
    .N(6)
  ) dut6 (
    .clk(clk),
    .rst(rst6),
    .in_data(in_data6),
    .in_valid(in_valid6),
    .in_ready(in_ready6),
    .mode(mode6),
    .sel(sel6),
    .out_data(out_data6),
    .out_valid(out_valid6),
    .out_ready(out_ready6),
    .out_grant(out_grant6)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference model of the 4-channel instance.
  bit m_init = 1'b0;
  bit m_valid;
  int m_data;
  int m_grant;
  int m_ptr;

  function automatic void model_win(output bit has, output int w);
    has = 1'b0;
    w   = 0;
    if (mode == 1'b0) begin
      if (int'(sel) < 4 && in_valid[sel]) begin
        has = 1'b1;
        w   = int'(sel);
      end
    end else begin
      for (int k = 1; k <= 4; k++) begin
        int c = (m_ptr + k) % 4;
        if (!has && in_valid[c]) begin
          has = 1'b1;
          w   = c;
        end
      end
    end
  endfunction

  always @(negedge clk) begin
    bit has;
    int w;
    bit load;
    logic [3:0] exp_rdy;
    model_win(has, w);
    load = !m_valid || out_ready;
    if (m_init) begin
      exp_rdy = (rst || !load || !has) ? 4'b0 : 4'(1 << w);
      check("cyc_in_ready", in_ready, exp_rdy);
      check("cyc_out_valid", out_valid, m_valid);
      check("cyc_out_data", out_data, m_data);
      check("cyc_out_grant", out_grant, m_grant);
    end
    if (rst) begin
      m_init  = 1'b1;
      m_valid = 1'b0;
      m_data  = 0;
      m_grant = 0;
      m_ptr   = 3;
    end else if (m_init && load) begin
      if (has) begin
        m_valid = 1'b1;
        m_data  = int'(in_data[w*8 +: 8]);
        m_grant = w;
        if (mode) m_ptr = w;
      end else begin
        m_valid = 1'b0;
      end
    end
  end

  initial begin
    rst = 1'b1; mode = 1'b0; sel = 2'd0; in_valid = '0; in_data = '0; out_ready = 1'b0;
    rst6 = 1'b1; mode6 = 1'b0; sel6 = 3'd0; in_valid6 = '0; in_data6 = '0; out_ready6 = 1'b0;
    cyc();
    cyc();
    check("reset_out_valid", out_valid, 0);
    check("reset_out_data", out_data, 0);
    check("reset_out_grant", out_grant, 0);

    // V1 fixed select
    rst = 1'b0; mode = 1'b0; sel = 2'd2; in_valid = 4'b1111; in_data = 32'h44A52211;
    out_ready = 1'b1;
    #1;
    check("v1_in_ready", in_ready, 4'b0100);
    cyc();
    check("v1_out_data", out_data, 8'hA5);
    check("v1_out_grant", out_grant, 2);
    check("v1_out_valid", out_valid, 1);

    // V2 round-robin after reset
    rst = 1'b1; mode = 1'b1; in_valid = 4'b1111;
    cyc();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      in_data = $urandom;
      cyc();
      check("v2_rr_grant", out_grant, k % 4);
    end

    // V3 round-robin skip over idle channels
    in_valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      in_data = $urandom;
      #1;
      check("v3_in_ready", in_ready, (k % 2 == 0) ? 4'b0010 : 4'b1000);
      cyc();
      check("v3_grant", out_grant, (k % 2 == 0) ? 1 : 3);
    end

    // V4 back-pressure
    mode = 1'b0; sel = 2'd1; in_valid = 4'b0010; in_data = 32'h00003C00; out_ready = 1'b1;
    cyc();
    check("v4_load", out_data, 8'h3C);
    out_ready = 1'b0; in_valid = 4'b1111; sel = 2'd2;
    for (int k = 0; k < 3; k++) begin
      in_data = $urandom;
      #1;
      check("v4_in_ready_stall", in_ready, 4'b0000);
      cyc();
      check("v4_hold_data", out_data, 8'h3C);
      check("v4_hold_valid", out_valid, 1);
      check("v4_hold_grant", out_grant, 1);
    end
    out_ready = 1'b1; in_valid = 4'b0000;
    cyc();
    check("v4_drained", out_valid, 0);

    // V5 select of an idle channel
    sel = 2'd0; in_valid = 4'b1110;
    #1;
    check("v5_in_ready", in_ready, 4'b0000);
    cyc();
    check("v5_out_valid", out_valid, 0);

    // V6 reset while FULL
    mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b0; in_data = 32'h12345678;
    cyc();
    check("v6_full", out_valid, 1);
    rst = 1'b1;
    #1;
    check("v6_rst_in_ready", in_ready, 4'b0000);
    cyc();
    check("v6_rst_valid", out_valid, 0);
    check("v6_rst_data", out_data, 0);
    rst = 1'b0; out_ready = 1'b1;
    cyc();
    check("v6_first_grant", out_grant, 0);
    check("v6_first_data", out_data, 8'h78);

    // Randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      rst       = ($urandom_range(0, 63) == 0);
      mode      = 1'($urandom);
      sel       = 2'($urandom);
      in_valid  = 4'($urandom);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      cyc();
    end
    rst = 1'b0; out_ready = 1'b1; in_valid = '0;

    // N = 6: round-robin wrap and out-of-range select
    mode6 = 1'b1; in_valid6 = 6'h3F; out_ready6 = 1'b1;
    cyc();
    rst6 = 1'b0;
    for (int k = 0; k < 7; k++) begin
      in_data6 = {$urandom, $urandom};
      cyc();
      check("n6_rr_grant", out_grant6, k % 6);
    end
    mode6 = 1'b0; sel6 = 3'd6;
    #1;
    check("n6_sel6_in_ready", in_ready6, 6'b000000);
    cyc();
    check("n6_sel6_out_valid", out_valid6, 0);
    sel6 = 3'd7;
    #1;
    check("n6_sel7_in_ready", in_ready6, 6'b000000);
    sel6 = 3'd5; in_data6 = 48'h5A0000000000;
    #1;
    check("n6_sel5_in_ready", in_ready6, 6'b100000);
    cyc();
    check("n6_sel5_data", out_data6, 8'h5A);
    check("n6_sel5_grant", out_grant6, 5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
